// File: rtl/snake_head_stepper.sv
// Snake head movement engine: divides clk into game ticks, commits a direction
// at each tick (rejecting 180-degree reversals) and runs the IDLE/RUN/OVER game FSM.
module snake_head_stepper #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int TICK_DIV = 2_500_000,
  parameter int START_X  = 20,
  parameter int START_Y  = 15,
  parameter bit WRAP     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  dir,
  output logic [5:0]  head_x,
  output logic [4:0]  head_y,
  output logic [1:0]  cur_dir,
  output logic        step,
  output logic [1:0]  state,
  output logic        game_over,
  output logic [15:0] step_cnt
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_LEFT  = 2'd1;
  localparam logic [1:0] D_DOWN  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    hx_q, hx_d;
  logic [4:0]    hy_q, hy_d;
  logic [1:0]    dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;
  logic [15:0]   sc_q, sc_d;

  logic [1:0] nd;
  logic [6:0] x7, nx7;
  logic [5:0] y6, ny6;
  logic       out_x, out_y, hit;

  // Candidate move for this tick; the extra top bit catches underflow at 0.
  always_comb begin
    nd = ((dir ^ 2'd2) == dir_q) ? dir_q : dir;
    x7 = {1'b0, hx_q};
    y6 = {1'b0, hy_q};
    case (nd)
      D_UP:    y6 = y6 - 6'd1;
      D_LEFT:  x7 = x7 - 7'd1;
      D_DOWN:  y6 = y6 + 6'd1;
      default: x7 = x7 + 7'd1;
    endcase
    out_x = x7[6] || (x7 >= 7'(GRID_W));
    out_y = y6[5] || (y6 >= 6'(GRID_H));
    nx7 = x7;
    ny6 = y6;
    if (x7[6])                nx7 = 7'(GRID_W - 1);
    else if (x7 >= 7'(GRID_W)) nx7 = 7'd0;
    if (y6[5])                ny6 = 6'(GRID_H - 1);
    else if (y6 >= 6'(GRID_H)) ny6 = 6'd0;
    hit = !WRAP && (out_x || out_y);
  end

  always_comb begin
    state_d = state_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    sc_d    = sc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (hit) begin
            state_d = OVER;
          end else begin
            hx_d   = nx7[5:0];
            hy_d   = ny6[4:0];
            dir_d  = nd;
            step_d = 1'b1;
            if (sc_q != 16'hFFFF) sc_d = sc_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OVER: begin
        if (start) begin
          state_d = RUN;
          hx_d    = 6'(START_X);
          hy_d    = 5'(START_Y);
          dir_d   = D_RIGHT;
          cnt_d   = '0;
          sc_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hx_q    <= 6'(START_X);
      hy_q    <= 5'(START_Y);
      dir_q   <= D_RIGHT;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      sc_q    <= sc_d;
    end
  end

  assign head_x    = hx_q;
  assign head_y    = hy_q;
  assign cur_dir   = dir_q;
  assign step      = step_q;
  assign state     = state_q;
  assign game_over = (state_q == OVER);
  assign step_cnt  = sc_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Directed bench for snake_head_stepper: one wall-mode and one wrap-mode instance
// on an 8x6 grid with a 4-cycle tick, checked against hand-computed values.
module tb_snake_head_stepper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [1:0] dir0 = 2'd3, dir1 = 2'd3;

  logic [5:0]  hx0, hx1;
  logic [4:0]  hy0, hy1;
  logic [1:0]  cd0, cd1, st0, st1;
  logic        stp0, stp1, go0, go1;
  logic [15:0] sc0, sc1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  snake_head_stepper #(.GRID_W(8), .GRID_H(6), .TICK_DIV(4), .START_X(4),
                       .START_Y(3), .WRAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .dir(dir0),
    .head_x(hx0), .head_y(hy0), .cur_dir(cd0), .step(stp0),
    .state(st0), .game_over(go0), .step_cnt(sc0));

  snake_head_stepper #(.GRID_W(8), .GRID_H(6), .TICK_DIV(4), .START_X(4),
                       .START_Y(3), .WRAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .dir(dir1),
    .head_x(hx1), .head_y(hy1), .cur_dir(cd1), .step(stp1),
    .state(st1), .game_over(go1), .step_cnt(sc1));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check0(input string tag, input int x, input int y, input int cd,
                        input int st, input int stp, input int sc);
    check({tag, ".x"},    16'(hx0),  16'(x));
    check({tag, ".y"},    16'(hy0),  16'(y));
    check({tag, ".dir"},  16'(cd0),  16'(cd));
    check({tag, ".state"}, 16'(st0), 16'(st));
    check({tag, ".step"}, 16'(stp0), 16'(stp));
    check({tag, ".cnt"},  sc0,       16'(sc));
    check({tag, ".over"}, 16'(go0),  16'(st == 2));
  endtask

  task automatic check1(input string tag, input int x, input int y, input int st,
                        input int stp, input int sc);
    check({tag, ".x"},     16'(hx1),  16'(x));
    check({tag, ".y"},     16'(hy1),  16'(y));
    check({tag, ".state"}, 16'(st1),  16'(st));
    check({tag, ".step"},  16'(stp1), 16'(stp));
    check({tag, ".cnt"},   sc1,       16'(sc));
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    check0("reset", 4, 3, 3, 0, 0, 0);
    check1("reset1", 4, 3, 0, 0, 0);

    // Start at edge E; steps land on E+4, E+8, E+12.
    start0 = 1'b1; dir0 = 2'd3;
    cyc(1);
    start0 = 1'b0;
    check0("start", 4, 3, 3, 1, 0, 0);
    cyc(3);
    check0("pre_step1", 4, 3, 3, 1, 0, 0);
    cyc(1);
    check0("step1", 5, 3, 3, 1, 1, 1);
    cyc(1);
    check("step1_pulse_end", 16'(stp0), 16'd0);
    cyc(3);
    check0("step2", 6, 3, 3, 1, 1, 2);
    cyc(4);
    check0("step3", 7, 3, 3, 1, 1, 3);

    // Wall hit to the right.
    cyc(4);
    check0("wall", 7, 3, 3, 2, 0, 3);
    cyc(4);
    check0("over_hold", 7, 3, 3, 2, 0, 3);

    // Restart from OVER with a reversal request already present.
    start0 = 1'b1; dir0 = 2'd1;
    cyc(1);
    start0 = 1'b0;
    check0("restart", 4, 3, 3, 1, 0, 0);
    cyc(3);
    check0("restart_pre", 4, 3, 3, 1, 0, 0);
    cyc(1);
    check0("reversal", 5, 3, 3, 1, 1, 1);

    start0 = 1'b1;
    dir0 = 2'd2;
    cyc(4);
    start0 = 1'b0;
    check0("turn_down", 5, 4, 2, 1, 1, 2);

    // Last value before the tick wins.
    dir0 = 2'd0;
    cyc(1);
    dir0 = 2'd1;
    cyc(3);
    check0("last_value", 4, 4, 1, 1, 1, 3);

    // Reset asserted on a step edge.
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check0("rst_on_step", 4, 3, 3, 0, 0, 0);

    // Wrap instance: up 3, left 4, then wrap left, up, right.
    start1 = 1'b1; dir1 = 2'd0;
    cyc(1);
    start1 = 1'b0;
    cyc(12);
    check1("up3", 4, 0, 1, 1, 3);
    dir1 = 2'd1;
    cyc(16);
    check1("left4", 0, 0, 1, 1, 7);
    cyc(4);
    check1("wrap_left", 7, 0, 1, 1, 8);
    check("wrap_left.over", 16'(go1), 16'd0);
    dir1 = 2'd0;
    cyc(4);
    check1("wrap_up", 7, 5, 1, 1, 9);
    check("wrap_up.dir", 16'(cd1), 16'd0);
    dir1 = 2'd3;
    cyc(4);
    check1("wrap_right", 0, 5, 1, 1, 10);
    check("idle_hold0", 16'(st0), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
